write_buffer: RTL

WRITE_BUFFER -- requirements
Module: write_buffer

---
 rtl/write_buffer_pkg.sv | 22 ++
 rtl/write_buffer_fifo.sv | 60 ++++++
 rtl/write_buffer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/write_buffer_pkg.sv
// Shared types for the posted-write buffer between the cache controller and ram.
// Entry fields are sized for the widest supported bus; the top narrows them back to its own widths.
package write_buffer_pkg;

   localparam int WB_ADDR_MAX = 32;
   localparam int WB_DATA_MAX = 64;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_WAIT,
      RD_REQ,
      RD_WAIT
   } wb_state_t;

   typedef struct packed {
      logic [WB_ADDR_MAX-1:0] addr;
      logic [3:0]             be;
      logic [WB_DATA_MAX-1:0] wdata;
   } wb_entry_t;

endpackage

// File: rtl/write_buffer_fifo.sv
// Circular store of pending write entries; head is the oldest entry, readable without latency.
module wb_fifo
   import write_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  wb_entry_t              push_entry,
   input  logic                   pop,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output wb_entry_t              head
);

   localparam int PW    = $clog2(DEPTH);
   localparam int CNT_W = PW + 1;

   wb_entry_t         mem_reg [DEPTH];
   logic [PW-1:0]     wr_ptr_reg;
   logic [PW-1:0]     rd_ptr_reg;
   logic [CNT_W-1:0]  count_reg;
   logic              do_push;
   logic              do_pop;

   // A full buffer refuses a push even when a pop lands on the same edge.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg] <= push_entry;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign full  = (count_reg == CNT_W'(DEPTH));
   assign empty = (count_reg == '0);
   assign count = count_reg;
   assign head  = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/write_buffer.sv
// Posted-write buffer: writes are acknowledged at once and drained to ram in order;
// reads wait until every buffered write has landed, then go straight through.
module write_buffer
   import write_buffer_pkg::*;
#(
   parameter int ADDR_WIDTH = 22,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ctrl_req,
   input  logic                  ctrl_we,
   input  logic [ADDR_WIDTH-1:0] ctrl_addr,
   input  logic [3:0]            ctrl_be,
   input  logic [DATA_WIDTH-1:0] ctrl_wdata,
   output logic                  ctrl_gnt,
   output logic                  ctrl_rvalid,
   output logic [DATA_WIDTH-1:0] ctrl_rdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [3:0]            mem_be,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  wb_empty
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   wb_state_t             state_reg, state_next;
   logic                  write_gnt, read_gnt, rd_busy, pop, rd_done;
   logic                  fifo_full, fifo_empty;
   logic [CNT_W-1:0]      fifo_count;
   wb_entry_t             push_entry, head;
   logic [ADDR_WIDTH-1:0] rd_addr_reg;
   logic [3:0]            rd_be_reg;
   logic                  ack_reg;
   logic [DATA_WIDTH-1:0] rdata_reg;

   assign rd_busy   = (state_reg == RD_REQ) || (state_reg == RD_WAIT);
   assign write_gnt = ~reset & ctrl_req & ctrl_we & ~fifo_full & ~rd_busy;
   assign read_gnt  = ~reset & ctrl_req & ~ctrl_we & fifo_empty & (state_reg == IDLE);
   assign ctrl_gnt  = write_gnt | read_gnt;
   assign pop       = (state_reg == WR_WAIT) & mem_rvalid;
   assign rd_done   = (state_reg == RD_WAIT) & mem_rvalid;

   assign push_entry = '{addr:  WB_ADDR_MAX'(ctrl_addr),
                         be:    ctrl_be,
                         wdata: WB_DATA_MAX'(ctrl_wdata)};

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (reset),
      .push       (write_gnt),
      .push_entry (push_entry),
      .pop        (pop),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (fifo_count),
      .head       (head)
   );

   // ctrl_rvalid serves both the posted-write ack and read data; the two can never coincide.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         ack_reg     <= 1'b0;
         rdata_reg   <= '0;
         rd_addr_reg <= '0;
         rd_be_reg   <= '0;
      end else begin
         state_reg <= state_next;
         ack_reg   <= write_gnt | rd_done;
         if (rd_done) rdata_reg <= mem_rdata;
         if (read_gnt) begin
            rd_addr_reg <= ctrl_addr;
            rd_be_reg   <= ctrl_be;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_be     = '0;
      mem_wdata  = '0;
      case (state_reg)
         IDLE: begin
            if (!fifo_empty)   state_next = WR_REQ;
            else if (read_gnt) state_next = RD_REQ;
         end
         WR_REQ: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ADDR_WIDTH'(head.addr);
            mem_be    = head.be;
            mem_wdata = DATA_WIDTH'(head.wdata);
            if (mem_gnt) state_next = WR_WAIT;
         end
         WR_WAIT: begin
            // A push landing with the pop keeps the drain going without an IDLE bubble.
            if (mem_rvalid) begin
               state_next = (fifo_count > CNT_W'(1) || write_gnt) ? WR_REQ : IDLE;
            end
         end
         RD_REQ: begin
            mem_req  = 1'b1;
            mem_addr = rd_addr_reg;
            mem_be   = rd_be_reg;
            if (mem_gnt) state_next = RD_WAIT;
         end
         RD_WAIT: begin
            if (mem_rvalid) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign ctrl_rvalid = ack_reg;
   assign ctrl_rdata  = rdata_reg;
   assign wb_empty    = fifo_empty & (state_reg == IDLE);

endmodule
